// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause codes, counter widths.
// Pure declarations; no timing or backpressure of its own.
package rst_pkg;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_EXT  = 2'd0,
      CAUSE_SOFT = 2'd1,
      CAUSE_WDT  = 2'd2
   } cause_t;

   localparam int RST_CNT_W = 8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Control/status bundle between the reset sequencer and its user.
// Requests are single-cycle strobes; status outputs are registered, no backpressure.
interface rst_seq_if #(
   parameter int NUM_DOMAINS = 2
) ();
   import rst_pkg::*;

   logic                   soft_req;
   logic                   wdt_kick;
   logic [NUM_DOMAINS-1:0] rst_out;
   logic                   busy;
   logic [1:0]             cause;
   logic [RST_CNT_W-1:0]   reset_count;

   modport master (
      output soft_req, wdt_kick,
      input  rst_out, busy, cause, reset_count
   );

   modport slave (
      input  soft_req, wdt_kick,
      output rst_out, busy, cause, reset_count
   );

endinterface

// File: rtl/rst_seq_wdt_cnt.sv
// Watchdog counter: flags expiry combinationally in the cycle the terminal count is seen un-kicked.
// Counter restarts on clear, kick or expiry; no backpressure.
module wdt_cnt #(
   parameter int WDT_CYCLES = 1024,
   parameter int WDT_EN     = 1
) (
   input  logic clk,
   input  logic clear,
   input  logic enable,
   input  logic kick,
   output logic expire
);

   localparam int             W_W    = $clog2(WDT_CYCLES);
   localparam logic [W_W-1:0] W_LAST = W_W'(WDT_CYCLES - 1);

   logic [W_W-1:0] wdt;

   assign expire = (WDT_EN != 0) && enable && !kick && (wdt == W_LAST);

   // With the watchdog disabled the count simply wraps, so it never saturates or overflows.
   always_ff @(posedge clk) begin
      if (clear) begin
         wdt <= '0;
      end else if (enable) begin
         if (kick || (wdt == W_LAST)) begin
            wdt <= '0;
         end else begin
            wdt <= wdt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds all domains, releases them one by one, then watches for soft/watchdog re-resets.
// Outputs change on the edge after the triggering input; requests are never stalled.
module rst_seq
   import rst_pkg::*;
#(
   parameter int NUM_DOMAINS    = 2,
   parameter int HOLD_CYCLES    = 4,
   parameter int STAGGER_CYCLES = 2,
   parameter int WDT_EN         = 1,
   parameter int WDT_CYCLES     = 1024
) (
   input logic     clk,
   input logic     rst,
   rst_seq_if.slave bus
);

   localparam int CNT_MAX = max3(HOLD_CYCLES, STAGGER_CYCLES, WDT_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] S_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [IDX_W-1:0] I_LAST = IDX_W'(NUM_DOMAINS - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic             expire;
   logic             wdt_clear;
   logic             reenter;

   // Soft requests are honoured outside HOLD; expiry can only assert in RUN.
   assign reenter   = (bus.soft_req && (state != ST_HOLD)) || expire;
   assign wdt_clear = rst || (state != ST_RUN) || bus.soft_req;

   wdt_cnt #(
      .WDT_CYCLES (WDT_CYCLES),
      .WDT_EN     (WDT_EN)
   ) u_wdt (
      .clk    (clk),
      .clear  (wdt_clear),
      .enable (state == ST_RUN),
      .kick   (bus.wdt_kick),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_HOLD;
         cnt             <= '0;
         idx             <= '0;
         bus.rst_out     <= '1;
         bus.busy        <= 1'b1;
         bus.cause       <= CAUSE_EXT;
         bus.reset_count <= '0;
      end else if (reenter) begin
         state       <= ST_HOLD;
         cnt         <= '0;
         idx         <= '0;
         bus.rst_out <= '1;
         bus.busy    <= 1'b1;
         bus.cause   <= bus.soft_req ? CAUSE_SOFT : CAUSE_WDT;
         if (bus.reset_count != '1) begin
            bus.reset_count <= bus.reset_count + 1'b1;
         end
      end else begin
         case (state)
            ST_HOLD: begin
               if (cnt == H_LAST) begin
                  state       <= ST_RELEASE;
                  cnt         <= '0;
                  idx         <= '0;
                  bus.rst_out <= bus.rst_out << 1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RELEASE: begin
               if (cnt == S_LAST) begin
                  cnt <= '0;
                  if (idx == I_LAST) begin
                     state    <= ST_RUN;
                     bus.busy <= 1'b0;
                  end else begin
                     // Domains drop in index order, so a left shift frees the next one.
                     idx         <= idx + 1'b1;
                     bus.rst_out <= bus.rst_out << 1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RUN: begin
               cnt <= '0;
            end
            default: begin
               state       <= ST_HOLD;
               cnt         <= '0;
               idx         <= '0;
               bus.rst_out <= '1;
               bus.busy    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: timeline model of both an enabled- and a disabled-watchdog instance.
// Directed stimulus with literal checkpoints plus a per-cycle model comparison.
module tb_rst_seq;

   localparam int N     = 2;
   localparam int H     = 4;
   localparam int S     = 2;
   localparam int W     = 16;
   localparam int RUN_T = H + N * S;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   rst_seq_if #(.NUM_DOMAINS(N)) bus_a ();
   rst_seq_if #(.NUM_DOMAINS(N)) bus_b ();

   rst_seq #(.NUM_DOMAINS(N), .HOLD_CYCLES(H), .STAGGER_CYCLES(S),
             .WDT_EN(1), .WDT_CYCLES(W)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   rst_seq #(.NUM_DOMAINS(N), .HOLD_CYCLES(H), .STAGGER_CYCLES(S),
             .WDT_EN(0), .WDT_CYCLES(W)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   // Model: t = edges since the sequence (re)started, idle = RUN cycles since entry or kick.
   int m_t[2], m_idle[2], m_cause[2], m_cnt[2];
   bit m_valid = 1'b0;
   bit wen[2] = '{1'b1, 1'b0};

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         bit s, k, run, ex;
         s   = (d == 0) ? bus_a.soft_req : bus_b.soft_req;
         k   = (d == 0) ? bus_a.wdt_kick : bus_b.wdt_kick;
         run = m_t[d] >= RUN_T;
         ex  = run && wen[d] && (m_idle[d] == W - 1) && !k;
         if (rst) begin
            m_t[d] = 0; m_idle[d] = 0; m_cause[d] = 0; m_cnt[d] = 0;
         end else if ((m_t[d] >= H && s) || ex) begin
            m_cause[d] = s ? 1 : 2;
            if (m_cnt[d] < 255) m_cnt[d] = m_cnt[d] + 1;
            m_t[d] = 0; m_idle[d] = 0;
         end else if (run) begin
            m_idle[d] = k ? 0 : (m_idle[d] + 1) % W;
         end else begin
            m_t[d] = m_t[d] + 1;
         end
      end
      if (rst) m_valid = 1'b1;
   end

   function automatic logic [N-1:0] exp_rst_out(input int t);
      logic [N-1:0] r;
      for (int k = 0; k < N; k++) r[k] = (t < H + k * S);
      return r;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         cmp("a.rst_out", 32'(bus_a.rst_out), 32'(exp_rst_out(m_t[0])));
         cmp("a.busy", 32'(bus_a.busy), 32'(m_t[0] < RUN_T));
         cmp("a.cause", 32'(bus_a.cause), 32'(m_cause[0]));
         cmp("a.reset_count", 32'(bus_a.reset_count), 32'(m_cnt[0]));
         cmp("b.rst_out", 32'(bus_b.rst_out), 32'(exp_rst_out(m_t[1])));
         cmp("b.busy", 32'(bus_b.busy), 32'(m_t[1] < RUN_T));
         cmp("b.cause", 32'(bus_b.cause), 32'(m_cause[1]));
         cmp("b.reset_count", 32'(bus_b.reset_count), 32'(m_cnt[1]));
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   logic [1:0] rel_tab  [8] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
   logic       busy_tab [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      bus_a.soft_req = 1'b0; bus_a.wdt_kick = 1'b0;
      bus_b.soft_req = 1'b0; bus_b.wdt_kick = 1'b0;

      // Release sequence from the external reset.
      tick();
      pulse_rst();
      cmp("lit.reset_rst_out", 32'(bus_a.rst_out), 32'h3);
      cmp("lit.reset_busy", 32'(bus_a.busy), 32'h1);
      for (int e = 1; e <= 8; e++) begin
         tick();
         cmp($sformatf("lit.rel_rst_out_e%0d", e), 32'(bus_a.rst_out), 32'(rel_tab[e-1]));
         cmp($sformatf("lit.rel_busy_e%0d", e), 32'(bus_a.busy), 32'(busy_tab[e-1]));
      end
      cmp("lit.rel_cause", 32'(bus_a.cause), 32'h0);
      cmp("lit.rel_count", 32'(bus_a.reset_count), 32'h0);

      // Watchdog expiry with no kicks, then the sequence reruns.
      tick(15);
      cmp("lit.wdt_pre_busy", 32'(bus_a.busy), 32'h0);
      tick();
      cmp("lit.wdt_rst_out", 32'(bus_a.rst_out), 32'h3);
      cmp("lit.wdt_cause", 32'(bus_a.cause), 32'h2);
      cmp("lit.wdt_count", 32'(bus_a.reset_count), 32'h1);
      tick(RUN_T - 1);
      cmp("lit.wdt_rerun_busy1", 32'(bus_a.busy), 32'h1);
      tick();
      cmp("lit.wdt_rerun_busy0", 32'(bus_a.busy), 32'h0);

      // Periodic kicks keep the watchdog quiet; a kick on the terminal cycle saves it.
      pulse_rst();
      tick(RUN_T);
      for (int i = 0; i < 200; i++) begin
         bus_a.wdt_kick = (i % 10 == 9);
         tick();
      end
      bus_a.wdt_kick = 1'b0;
      cmp("lit.kick_busy", 32'(bus_a.busy), 32'h0);
      cmp("lit.kick_count", 32'(bus_a.reset_count), 32'h0);
      tick(15);
      bus_a.wdt_kick = 1'b1;
      tick();
      bus_a.wdt_kick = 1'b0;
      cmp("lit.kick16_busy", 32'(bus_a.busy), 32'h0);
      tick(15);
      cmp("lit.kick16_after15", 32'(bus_a.busy), 32'h0);
      tick();
      cmp("lit.kick16_expire", 32'(bus_a.cause), 32'h2);

      // Soft request mid-release, then one ignored during HOLD.
      pulse_rst();
      tick(5);
      bus_a.soft_req = 1'b1;
      tick();
      bus_a.soft_req = 1'b0;
      cmp("lit.soft_rst_out", 32'(bus_a.rst_out), 32'h3);
      cmp("lit.soft_cause", 32'(bus_a.cause), 32'h1);
      cmp("lit.soft_count", 32'(bus_a.reset_count), 32'h1);
      bus_a.soft_req = 1'b1;
      tick();
      bus_a.soft_req = 1'b0;
      tick(2);
      cmp("lit.hold_soft_rst_out3", 32'(bus_a.rst_out), 32'h3);
      tick();
      cmp("lit.hold_soft_rst_out2", 32'(bus_a.rst_out), 32'h2);
      cmp("lit.hold_soft_count", 32'(bus_a.reset_count), 32'h1);

      // Soft request on the expiry cycle, then external reset mid-release.
      tick(RUN_T - H);
      tick(15);
      bus_a.soft_req = 1'b1;
      tick();
      bus_a.soft_req = 1'b0;
      cmp("lit.coinc_cause", 32'(bus_a.cause), 32'h1);
      cmp("lit.coinc_count", 32'(bus_a.reset_count), 32'h2);
      tick(5);
      pulse_rst();
      cmp("lit.midrel_rst_out", 32'(bus_a.rst_out), 32'h3);
      cmp("lit.midrel_cause", 32'(bus_a.cause), 32'h0);
      cmp("lit.midrel_count", 32'(bus_a.reset_count), 32'h0);
      tick(RUN_T);
      cmp("lit.midrel_run", 32'(bus_a.busy), 32'h0);

      // Disabled watchdog never fires; repeated soft resets saturate the count.
      tick(100);
      cmp("lit.nowdt_busy", 32'(bus_b.busy), 32'h0);
      cmp("lit.nowdt_count", 32'(bus_b.reset_count), 32'h0);
      for (int i = 0; i < 300; i++) begin
         bus_b.soft_req = 1'b1;
         tick();
         bus_b.soft_req = 1'b0;
         tick(RUN_T);
      end
      cmp("lit.sat_count", 32'(bus_b.reset_count), 32'd255);
      cmp("lit.sat_cause", 32'(bus_b.cause), 32'h1);
      cmp("lit.sat_busy", 32'(bus_b.busy), 32'h0);

      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Parametrised reset sequencer and watchdog for the mcu top level.
- Takes the board or bench reset and produces per-domain, staggered, active-high resets for the core, memories and peripherals.
- Re-enters the reset sequence on a software request or on watchdog expiry.
- Records the cause of the last reset and a saturating count of re-resets, so the bench can check it without pulsing the external reset several times.

Parameters:
- NUM_DOMAINS, 2: number of reset outputs; domain 0 releases first. Range ≥1.
- HOLD_CYCLES, 4: cycles all domains stay asserted after HOLD is entered. Range ≥1.
- STAGGER_CYCLES, 2: cycles between consecutive domain releases, and between the last release and RUN. Range ≥1.
- WDT_EN, 1: 1 enables the watchdog; 0 means it never fires.
- WDT_CYCLES, 1024: cycles without a kick in RUN before a watchdog reset. Range ≥2.
- CNT_W, derived: $clog2 of max(HOLD_CYCLES, STAGGER_CYCLES, WDT_CYCLES) + 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high external reset.
- soft_req  in  1  single-cycle software reset request.
- wdt_kick  in  1  clears the watchdog counter; honoured in RUN only.
- rst_out  out  NUM_DOMAINS  per-domain active-high reset, registered.
- busy  out  1  high in every state except RUN.
- cause  out  2  cause of the last reset: 0 = EXT, 1 = SOFT, 2 = WDT.
- reset_count  out  8  saturating count of SOFT and WDT resets.

Behaviour:
- States: HOLD, RELEASE, RUN. Internal registers: cnt (CNT_W bits), idx, wdt.
- rst=1, sampled at an edge:
  - state=HOLD, cnt=0, idx=0, wdt=0.
  - rst_out all ones, busy=1, cause=0, reset_count=0.
  - rst overrides every other input in every state, including mid-sequence.
- HOLD:
  - cnt increments each cycle.
  - On the edge where cnt==HOLD_CYCLES-1: state=RELEASE, cnt=0, idx=0, rst_out[0] cleared.
  - soft_req is ignored. wdt_kick is ignored.
- RELEASE:
  - cnt increments each cycle.
  - On the edge where cnt==STAGGER_CYCLES-1:
    - if idx==NUM_DOMAINS-1: state=RUN, busy=0, wdt=0;
    - otherwise: idx+1, rst_out[idx+1] cleared, cnt=0.
- Timing from the last edge with rst=1:
  - rst_out[k] falls after HOLD_CYCLES + k*STAGGER_CYCLES edges.
  - RUN is entered after HOLD_CYCLES + NUM_DOMAINS*STAGGER_CYCLES edges.
  - A deasserted domain never re-asserts, except through a re-entry to HOLD.
- RUN:
  - wdt increments each cycle; wdt_kick=1 loads wdt=0 on that edge.
  - Expiry: wdt==WDT_CYCLES-1 with no kick and WDT_EN=1.
- Re-entry to HOLD, triggered by soft_req in RUN or RELEASE, or by expiry in RUN:
  - On the same edge: state=HOLD, cnt=0, idx=0, wdt=0, rst_out all ones, busy=1.
  - cause=1 for soft_req, cause=2 for expiry.
  - reset_count+1, saturating at 255.
- Priority: rst > soft_req > wdt expiry. If soft_req and expiry coincide, cause=1 and the count increments once.
- wdt_kick in the same cycle as expiry prevents the expiry.
- With NUM_DOMAINS=1 the stagger phase still runs once before RUN.
- No combinational path from any input to any output; every output is a flop.

Decomposition:
- Shared package rst_pkg:
  - state enum ST_HOLD, ST_RELEASE, ST_RUN;
  - cause codes CAUSE_EXT=2'd0, CAUSE_SOFT=2'd1, CAUSE_WDT=2'd2;
  - RST_CNT_W=8.
- One sub-module, wdt_cnt:
  - inputs: clear, enable, kick;
  - output: a one-cycle expiry flag;
  - parameters: WDT_CYCLES and WDT_EN.
- The FSM and rst_out shift logic stay in rst_seq.
- Instantiated in the mcu top: rst_out[0] drives the core, rst_out[1] drives the peripherals.

Test Plan (N=2, H=4, S=2, WDT_CYCLES=16, WDT_EN=1 unless noted; edge 0 is the last edge with rst=1):
- Release sequence: pulse rst, then idle → rst_out=2'b11 through edge 3; 2'b10 after edge 4; 2'b00 after edge 6; busy=0 after edge 8; cause=0; reset_count=0.
- Watchdog expiry: reach RUN, never kick → after 16 edges in RUN, rst_out=2'b11, cause=2, reset_count=1; the sequence repeats and RUN is re-entered 8 edges later.
- Kicked watchdog: kick every 10 cycles for 200 cycles → busy stays 0, reset_count stays 0. Kick on exactly the 16th cycle → no reset.
- soft_req during release: soft_req after edge 5 → rst_out back to 2'b11, cause=1, reset_count=1. soft_req during HOLD is ignored: count unchanged, timing unchanged.
- Simultaneous events: soft_req in the expiry cycle → cause=1, reset_count+1 only. rst mid-RELEASE → full restart, reset_count=0, cause=0.
- Disabled watchdog and saturation: WDT_EN=0, run 100 cycles with no kick → no reset. Then issue 300 soft_req pulses, each after RUN is reached → reset_count saturates at 255.
